// File: rtl/rollover_sub_match_if.sv
// Trigger, hit and output handshake bundle for the coarse-time trigger matcher.
// The slave modport is the matcher's own view of the bundle.
interface rollover_sub_match_if #(
  parameter int WIDTH  = 12,
  parameter int DATA_W = 20
);
  logic              trigger_valid;
  logic [WIDTH-1:0]  trigger_time;
  logic              trigger_ready;

  logic              hit_valid;
  logic [WIDTH-1:0]  hit_time;
  logic [DATA_W-1:0] hit_data;
  logic              hit_ready;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_rel_time;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output trigger_valid, trigger_time,
    input  trigger_ready,
    output hit_valid, hit_time, hit_data,
    input  hit_ready,
    input  out_valid, out_rel_time, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  trigger_valid, trigger_time,
    output trigger_ready,
    input  hit_valid, hit_time, hit_data,
    output hit_ready,
    output out_valid, out_rel_time, out_data, out_last,
    input  out_ready
  );
endinterface

// File: rtl/rollover_sub_match.sv
// Trigger matcher on the coarse-time axis: modular window start, hit matching
// with relative times, and a per-event trailer carrying the matched-hit count.
module rollover_sub_match #(
  parameter int WIDTH  = 12,
  parameter int DATA_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rollover,
  input  logic [WIDTH-1:0]     match_offset,
  input  logic [WIDTH-1:0]     search_window,
  input  logic [WIDTH-1:0]     coarse_now,
  rollover_sub_match_if.slave  bus,
  output logic                 busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CALC    = 3'd1;
  localparam logic [2:0] ST_MATCH   = 3'd2;
  localparam logic [2:0] ST_TRAILER = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic              armed_reg;
  logic [WIDTH-1:0]  trig_time_reg;
  logic [WIDTH-1:0]  win_start_reg;
  logic [WIDTH-1:0]  hit_count_reg;

  logic              out_valid_reg;
  logic              out_last_reg;
  logic [WIDTH-1:0]  out_rel_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic [WIDTH-1:0]  rel_hit, rel_now;
  logic              in_match, closing, out_free;
  logic              trigger_ready, hit_ready;
  logic              trig_fire, hit_fire, hit_keep;
  logic              out_accept;
  logic [DATA_W-1:0] trailer_word;

  // (a - b) mod (m + 1), computed one bit wider so the wrap term cannot overflow.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] diff;
    if (a >= b)
      diff = {1'b0, a} - {1'b0, b};
    else
      diff = {1'b0, a} + {1'b0, m} + {{WIDTH{1'b0}}, 1'b1} - {1'b0, b};
    return diff[WIDTH-1:0];
  endfunction

  assign rel_hit  = mod_sub(bus.hit_time, win_start_reg, rollover);
  assign rel_now  = mod_sub(coarse_now, win_start_reg, rollover);

  assign in_match = (state_reg == ST_MATCH);
  assign closing  = in_match && (rel_now > search_window);
  assign out_free = !out_valid_reg || bus.out_ready;
  assign out_accept = out_valid_reg && bus.out_ready;

  // armed_reg keeps trigger_ready low while reset is held and until the first clock after it.
  assign trigger_ready = (state_reg == ST_IDLE) && armed_reg;
  assign hit_ready     = in_match && out_free && !closing;
  assign trig_fire     = bus.trigger_valid && trigger_ready;
  assign hit_fire      = bus.hit_valid && hit_ready;
  assign hit_keep      = hit_fire && (rel_hit <= search_window);

  // Trailer payload: hit count zero-extended (or truncated) to the payload width.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_trailer
    if (gi < WIDTH) begin : g_cnt
      assign trailer_word[gi] = hit_count_reg[gi];
    end else begin : g_pad
      assign trailer_word[gi] = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (trig_fire) state_next = ST_CALC;
      ST_CALC:    state_next = ST_MATCH;
      ST_MATCH:   if (closing) state_next = ST_TRAILER;
      ST_TRAILER: if (out_free) state_next = ST_DONE;
      ST_DONE:    if (out_accept) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      armed_reg     <= 1'b0;
      trig_time_reg <= '0;
      win_start_reg <= '0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      if (trig_fire)
        trig_time_reg <= bus.trigger_time;
      if (state_reg == ST_CALC)
        win_start_reg <= mod_sub(trig_time_reg, match_offset, rollover);
    end
  end

  // Count saturates instead of wrapping; cleared only when the trailer leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg <= '0;
    end else if (hit_keep) begin
      if (hit_count_reg != '1)
        hit_count_reg <= hit_count_reg + 1'b1;
    end else if ((state_reg == ST_DONE) && out_accept) begin
      hit_count_reg <= '0;
    end
  end

  // Single output register; a same-cycle load after acceptance gives one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_rel_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      if (out_accept)
        out_valid_reg <= 1'b0;
      if (hit_keep) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= 1'b0;
        out_rel_reg   <= rel_hit;
        out_data_reg  <= bus.hit_data;
      end else if ((state_reg == ST_TRAILER) && out_free) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= 1'b1;
        out_rel_reg   <= '0;
        out_data_reg  <= trailer_word;
      end
    end
  end

  assign bus.trigger_ready = trigger_ready;
  assign bus.hit_ready     = hit_ready;
  assign bus.out_valid     = out_valid_reg;
  assign bus.out_last      = out_last_reg;
  assign bus.out_rel_time  = out_rel_reg;
  assign bus.out_data      = out_data_reg;
  assign busy              = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rollover_sub_match.sv
// Directed bench for rollover_sub_match: wrapping and non-wrapping windows,
// drops, backpressure, close collision and mid-event reset.
module tb_rollover_sub_match;
  localparam int WIDTH  = 12;
  localparam int DATA_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  rollover, match_offset, search_window, coarse_now;
  logic              busy;
  int                n_vec = 0;
  int                n_miscompare = 0;

  rollover_sub_match_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

  rollover_sub_match #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rollover      (rollover),
    .match_offset  (match_offset),
    .search_window (search_window),
    .coarse_now    (coarse_now),
    .bus           (bus),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_trigger(input logic [WIDTH-1:0] t, input string tag);
    coarse_now             = t;
    bus.trigger_time       = t;
    bus.trigger_valid      = 1'b1;
    #1;
    chk({tag, ".trig_ready"}, 32'(bus.trigger_ready), 32'd1);
    cyc();
    bus.trigger_valid = 1'b0;
    #1;
    chk({tag, ".calc_busy"}, 32'(busy), 32'd1);
    chk({tag, ".calc_trig_ready"}, 32'(bus.trigger_ready), 32'd0);
    chk({tag, ".calc_hit_ready"}, 32'(bus.hit_ready), 32'd0);
    cyc();
  endtask

  task automatic send_hit(input logic [WIDTH-1:0] t, input logic [DATA_W-1:0] d,
                          input bit keep, input logic [WIDTH-1:0] rel, input string tag);
    bus.hit_valid = 1'b1;
    bus.hit_time  = t;
    bus.hit_data  = d;
    #1;
    chk({tag, ".hit_ready"}, 32'(bus.hit_ready), 32'd1);
    cyc();
    bus.hit_valid = 1'b0;
    #1;
    if (keep) begin
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".out_rel"}, 32'(bus.out_rel_time), 32'(rel));
      chk({tag, ".out_data"}, 32'(bus.out_data), 32'(d));
      chk({tag, ".out_last"}, 32'(bus.out_last), 32'd0);
    end else begin
      chk({tag, ".dropped"}, 32'(bus.out_valid), 32'd0);
    end
    $display("hit   %s t=%0d kept=%0d", tag, t, keep);
  endtask

  task automatic close_event(input logic [WIDTH-1:0] now, input int cnt, input string tag);
    coarse_now = now;
    #1;
    chk({tag, ".closing_hit_ready"}, 32'(bus.hit_ready), 32'd0);
    cyc();
    chk({tag, ".trailer_busy"}, 32'(busy), 32'd1);
    cyc();
    chk({tag, ".trl_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".trl_last"}, 32'(bus.out_last), 32'd1);
    chk({tag, ".trl_count"}, 32'(bus.out_data), 32'(cnt));
    chk({tag, ".trl_rel"}, 32'(bus.out_rel_time), 32'd0);
    cyc();
    chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_trig_ready"}, 32'(bus.trigger_ready), 32'd1);
    $display("event %s closed, expected count %0d", tag, cnt);
  endtask

  initial begin
    rst               = 1'b1;
    rollover          = 12'd3563;
    match_offset      = 12'd20;
    search_window     = 12'd30;
    coarse_now        = '0;
    bus.trigger_valid = 1'b0;
    bus.trigger_time  = '0;
    bus.hit_valid     = 1'b0;
    bus.hit_time      = '0;
    bus.hit_data      = '0;
    bus.out_ready     = 1'b1;
    cyc();
    cyc();
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.trig_ready", 32'(bus.trigger_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.hit_ready", 32'(bus.hit_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst.trig_ready", 32'(bus.trigger_ready), 32'd1);

    // Window 3554..20 straddles the rollover.
    start_trigger(12'd10, "wrap");
    send_hit(12'd3560, 20'hAAAAA, 1'b1, 12'd6, "wrap.h1");
    send_hit(12'd5, 20'hBBBBB, 1'b1, 12'd15, "wrap.h2");
    close_event(12'd21, 2, "wrap");

    start_trigger(12'd10, "drop");
    send_hit(12'd3550, 20'h00001, 1'b0, 12'd0, "drop.h1");
    send_hit(12'd30, 20'h00002, 1'b0, 12'd0, "drop.h2");
    close_event(12'd21, 0, "drop");

    start_trigger(12'd10, "bp");
    bus.out_ready = 1'b0;
    send_hit(12'd3555, 20'h11111, 1'b1, 12'd1, "bp.h1");
    bus.hit_valid = 1'b1;
    bus.hit_time  = 12'd3556;
    bus.hit_data  = 20'h22222;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp.stall_hit_ready", 32'(bus.hit_ready), 32'd0);
      chk("bp.stall_rel", 32'(bus.out_rel_time), 32'd1);
      chk("bp.stall_data", 32'(bus.out_data), 32'h11111);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_hit_ready", 32'(bus.hit_ready), 32'd1);
    cyc();
    bus.hit_valid = 1'b0;
    chk("bp.h2_rel", 32'(bus.out_rel_time), 32'd2);
    chk("bp.h2_data", 32'(bus.out_data), 32'h22222);
    send_hit(12'd3557, 20'h33333, 1'b1, 12'd3, "bp.h3");
    send_hit(12'd0, 20'h44444, 1'b1, 12'd10, "bp.h4");
    close_event(12'd21, 4, "bp");

    // Hit arrives on the closing cycle: it must wait for the next trigger.
    start_trigger(12'd10, "coll");
    coarse_now    = 12'd21;
    bus.hit_valid = 1'b1;
    bus.hit_time  = 12'd95;
    bus.hit_data  = 20'hCCCCC;
    #1;
    chk("coll.hit_ready", 32'(bus.hit_ready), 32'd0);
    cyc();
    chk("coll.trailer_hit_ready", 32'(bus.hit_ready), 32'd0);
    cyc();
    chk("coll.trl_count", 32'(bus.out_data), 32'd0);
    chk("coll.trl_last", 32'(bus.out_last), 32'd1);
    cyc();
    chk("coll.idle_busy", 32'(busy), 32'd0);
    $display("event coll closed, expected count 0");
    start_trigger(12'd100, "coll2");
    #1;
    chk("coll2.hit_ready", 32'(bus.hit_ready), 32'd1);
    cyc();
    bus.hit_valid = 1'b0;
    chk("coll2.out_valid", 32'(bus.out_valid), 32'd1);
    chk("coll2.out_rel", 32'(bus.out_rel_time), 32'd15);
    chk("coll2.out_data", 32'(bus.out_data), 32'hCCCCC);
    close_event(12'd111, 1, "coll2");

    rollover      = 12'd4095;
    match_offset  = 12'd0;
    search_window = 12'd0;
    start_trigger(12'd4095, "edge");
    send_hit(12'd4094, 20'h00010, 1'b0, 12'd0, "edge.h1");
    send_hit(12'd4095, 20'h00020, 1'b1, 12'd0, "edge.h2");
    send_hit(12'd0, 20'h00030, 1'b0, 12'd0, "edge.h3");
    close_event(12'd0, 1, "edge");

    rollover      = 12'd3563;
    match_offset  = 12'd20;
    search_window = 12'd30;
    start_trigger(12'd10, "rst");
    send_hit(12'd3560, 20'h55555, 1'b1, 12'd6, "rst.h1");
    rst = 1'b1;
    #1;
    chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid.out_data", 32'(bus.out_data), 32'd0);
    chk("rst_mid.out_rel", 32'(bus.out_rel_time), 32'd0);
    chk("rst_mid.out_last", 32'(bus.out_last), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.trig_ready", 32'(bus.trigger_ready), 32'd0);
    chk("rst_mid.hit_ready", 32'(bus.hit_ready), 32'd0);
    cyc();
    chk("rst_mid.no_trailer", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("rst_mid.rearmed", 32'(bus.trigger_ready), 32'd1);
    start_trigger(12'd10, "after_rst");
    send_hit(12'd5, 20'h66666, 1'b1, 12'd15, "after_rst.h1");
    close_event(12'd21, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
